// File: rtl/inst_fetch_axi_pkg.sv
// inst_fetch_axi_pkg: shared state encodings and AXI constants for the instruction fetcher
package inst_fetch_axi_pkg;
  typedef enum logic [1:0] {FETCH, WAIT_R, HOLD, DRAIN} state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [2:0] ARPROT_INST = 3'b100;
  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/inst_fetch_axi.sv
// inst_fetch_axi: IF-stage PC holder fetching one instruction per PC over an AXI4-Lite read channel
module inst_fetch_axi
  import inst_fetch_axi_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic [1:0]        if_excp,
  output logic              stallreq_if,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, redir_pc, redir_pc_n, next_pc;
  logic redir, redir_n, adel, ar_hs, rok;
  logic [DATA_W-1:0] inst_buf, inst_n;
  logic [1:0] excp, excp_n;
  logic unused_stall;
  assign unused_stall = ^stall[5:1];
  assign adel = pc[1:0] != 2'b00;
  assign m_arvalid = !rst && state == FETCH && !adel;
  assign m_araddr = pc;
  assign m_arprot = ARPROT_INST;
  assign m_rready = !rst && (state == WAIT_R || state == DRAIN);
  assign ar_hs = m_arvalid && m_arready;
  assign rok = m_rresp == RESP_OKAY;
  assign next_pc = branch_flag ? branch_target : pc + ADDR_W'(4);
  assign stallreq_if = state != HOLD;
  assign if_pc = pc;
  assign if_inst = state == HOLD ? inst_buf : '0;
  assign if_excp = state == HOLD ? excp : 2'b00;
  // next state, PC redirect and delivered-instruction bookkeeping; flush outranks stall and branch
  always_comb begin
    state_n = state;
    pc_n = pc;
    redir_n = redir;
    redir_pc_n = redir_pc;
    inst_n = inst_buf;
    excp_n = excp;
    case (state)
      FETCH: begin
        if (adel) begin
          state_n = flush ? FETCH : HOLD;
          pc_n = flush ? new_pc : pc;
          inst_n = flush ? inst_buf : '0;
          excp_n = flush ? excp : 2'b01;
        end else if (ar_hs) begin
          state_n = (flush || redir) ? DRAIN : WAIT_R;
          pc_n = flush ? new_pc : redir ? redir_pc : pc;
          redir_n = 1'b0;
        end else if (flush) begin
          redir_n = 1'b1;
          redir_pc_n = new_pc;
        end
      end
      WAIT_R: begin
        state_n = flush ? (m_rvalid ? FETCH : DRAIN) : m_rvalid ? HOLD : WAIT_R;
        pc_n = flush ? new_pc : pc;
        inst_n = (!flush && m_rvalid) ? (rok ? m_rdata : '0) : inst_buf;
        excp_n = (!flush && m_rvalid) ? {!rok, 1'b0} : excp;
      end
      HOLD: begin
        state_n = (flush || !stall[0]) ? FETCH : HOLD;
        pc_n = flush ? new_pc : !stall[0] ? next_pc : pc;
        excp_n = (flush || !stall[0]) ? 2'b00 : excp;
      end
      default: begin
        state_n = m_rvalid ? FETCH : DRAIN;
        pc_n = flush ? new_pc : pc;
      end
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC[ADDR_W-1:0];
      redir <= 1'b0;
      redir_pc <= '0;
      inst_buf <= '0;
      excp <= 2'b00;
    end else begin
      state <= state_n;
      pc <= pc_n;
      redir <= redir_n;
      redir_pc <= redir_pc_n;
      inst_buf <= inst_n;
      excp <= excp_n;
    end
  end
endmodule
